// File: rtl/button_decoder_pkg.sv
// button_decoder_pkg: button command codes, SET FSM states and counter sizing shared with the time counter
package button_decoder_pkg;

   localparam logic [1:0] BTN_NONE = 2'd0;
   localparam logic [1:0] BTN_SET  = 2'd1;
   localparam logic [1:0] BTN_MODE = 2'd2;

   typedef enum logic [1:0] {
      SET_IDLE   = 2'd0,
      SET_HELD   = 2'd1,
      SET_REPEAT = 2'd2
   } set_state_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronise an active-low raw button, debounce it and flag the press edge
module button_debounce
   import button_decoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_n,
   output logic level,
   output logic press
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable_n;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_done;

   // a level change is accepted once the synchronised input has disagreed for the full window
   always_comb begin
      w_diff = r_sync2 != r_stable_n;
      w_done = w_diff && (r_cnt == LAST);
      level  = ~r_stable_n;
      press  = level & ~r_level_d;
   end

   // synchroniser, debounce counter and previous level for edge detection
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_stable_n <= 1'b1;
         r_level_d  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync1    <= raw_n;
         r_sync2    <= r_sync1;
         r_stable_n <= w_done ? r_sync2 : r_stable_n;
         r_level_d  <= ~r_stable_n;
         r_cnt      <= (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/button_decoder.sv
// button_decoder: turns MODE/SET button presses into single-cycle commands, with SET auto-repeat
module button_decoder
   import button_decoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 25_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode_n,
   input  logic       btn_set_n,
   output logic [1:0] button_state,
   output logic       mode_lvl,
   output logic       set_lvl
);

   localparam int HW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

   set_state_t    r_state;
   set_state_t    w_state_nx;
   logic [HW-1:0] r_hold_cnt;
   logic [HW-1:0] w_hold_nx;
   logic [1:0]    r_button_state;
   logic [1:0]    w_button_nx;
   logic          w_mode_press;
   logic          w_set_press;
   logic          w_set_emit;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
      .clk   (clk),
      .reset (reset),
      .raw_n (btn_mode_n),
      .level (mode_lvl),
      .press (w_mode_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
      .clk   (clk),
      .reset (reset),
      .raw_n (btn_set_n),
      .level (set_lvl),
      .press (w_set_press)
   );

   // SET press/hold/repeat sequencing; MODE held parks the FSM so SET needs a fresh press afterwards
   always_comb begin
      w_state_nx = r_state;
      w_hold_nx  = r_hold_cnt;
      w_set_emit = 1'b0;
      if (mode_lvl) begin
         w_state_nx = SET_IDLE;
         w_hold_nx  = '0;
      end else begin
         case (r_state)
            SET_IDLE: begin
               if (w_set_press) begin
                  w_set_emit = 1'b1;
                  w_state_nx = SET_HELD;
                  w_hold_nx  = '0;
               end
            end
            SET_HELD: begin
               if (!set_lvl) begin
                  w_state_nx = SET_IDLE;
                  w_hold_nx  = '0;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  w_set_emit = 1'b1;
                  w_state_nx = SET_REPEAT;
                  w_hold_nx  = '0;
               end else begin
                  w_hold_nx  = r_hold_cnt + 1'b1;
               end
            end
            SET_REPEAT: begin
               if (!set_lvl) begin
                  w_state_nx = SET_IDLE;
                  w_hold_nx  = '0;
               end else if (r_hold_cnt == REP_LAST) begin
                  w_set_emit = 1'b1;
                  w_hold_nx  = '0;
               end else begin
                  w_hold_nx  = r_hold_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nx = SET_IDLE;
               w_hold_nx  = '0;
            end
         endcase
      end
      w_button_nx = w_mode_press ? BTN_MODE : w_set_emit ? BTN_SET : BTN_NONE;
   end

   // FSM state, hold counter and the registered command bus
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= SET_IDLE;
         r_hold_cnt     <= '0;
         r_button_state <= BTN_NONE;
      end else begin
         r_state        <= w_state_nx;
         r_hold_cnt     <= w_hold_nx;
         r_button_state <= w_button_nx;
      end
   end

   assign button_state = r_button_state;

endmodule

// File: tb/tb_button_decoder.sv
// tb_button_decoder: directed scenarios plus random button/reset activity against a schedule-based reference
module tb_button_decoder;
   import button_decoder_pkg::*;

   localparam int D = 4;
   localparam int H = 10;
   localparam int R = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode_n = 1'b1;
   logic       btn_set_n = 1'b1;
   logic [1:0] button_state;
   logic       mode_lvl;
   logic       set_lvl;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   bit armed = 1'b0;
   int lc[$];
   int lv[$];

   button_decoder #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_mode_n   (btn_mode_n),
      .btn_set_n    (btn_set_n),
      .button_state (button_state),
      .mode_lvl     (mode_lvl),
      .set_lvl      (set_lvl)
   );

   always #5 clk = ~clk;

   // reference: raw history per button (index 0 newest), levels, and a SET pulse schedule by age since press
   bit [D:0]   hm, hs;
   bit         m_mode, m_set, m_mrose, m_srose, s_act, nm, ns;
   int         age;
   logic [1:0] m_bs;

   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         m_bs = BTN_NONE;
         m_mode = 0; m_set = 0; m_mrose = 0; m_srose = 0; s_act = 0; age = 0;
         hm = '1; hs = '1;
      end else begin
         m_bs = m_mrose ? BTN_MODE : BTN_NONE;
         if (m_mode) s_act = 0;
         else if (s_act) begin
            if (!m_set) s_act = 0;
            else begin
               age++;
               if (age == H || (age > H && (age - H) % R == 0)) m_bs = BTN_SET;
            end
         end else if (m_srose) begin
            s_act = 1; age = 0; m_bs = BTN_SET;
         end
         nm = (hm[D:1] == {D{m_mode}}) ? ~m_mode : m_mode;
         ns = (hs[D:1] == {D{m_set}}) ? ~m_set : m_set;
         hm = {hm[D-1:0], btn_mode_n};
         hs = {hs[D-1:0], btn_set_n};
         m_mrose = nm & ~m_mode;
         m_srose = ns & ~m_set;
         m_mode = nm;
         m_set = ns;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("model button_state", button_state, m_bs);
         chk("model mode_lvl", mode_lvl, m_mode);
         chk("model set_lvl", set_lvl, m_set);
      end
   end

   always @(negedge clk) begin
      if (armed && button_state != 2'd0) begin
         lc.push_back(cyc);
         lv.push_back(button_state);
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_log(input string name, input int ec[$], input int ev[$]);
      chk({name, " pulse count"}, lc.size(), ec.size());
      for (int i = 0; i < ec.size() && i < lc.size(); i++) begin
         chk({name, " pulse cycle"}, lc[i], ec[i]);
         chk({name, " pulse code"}, lv[i], ev[i]);
      end
      lc.delete();
      lv.delete();
   endtask

   int ec[$];
   int ev[$];
   int c0, c1, c2, p, r, mh, sh, rh;

   initial begin
      @(negedge clk);
      armed = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("reset button_state", button_state, 0);
         chk("reset levels", {mode_lvl, set_lvl}, 0);
         cycles(1);
      end
      reset = 1'b1;
      cycles(12);
      chk("idle button_state", button_state, 0);
      chk("idle levels", {mode_lvl, set_lvl}, 0);
      ec = {}; ev = {};
      check_log("idle", ec, ev);

      btn_mode_n = 1'b0; c0 = cyc;
      cycles(5);
      chk("mode_lvl before accept", mode_lvl, 0);
      cycles(1);
      chk("mode_lvl after accept", mode_lvl, 1);
      cycles(14);
      btn_mode_n = 1'b1;
      cycles(12);
      ec = {c0 + 7}; ev = {2};
      check_log("mode press", ec, ev);

      btn_set_n = 1'b0; c0 = cyc;
      cycles(3);
      btn_set_n = 1'b1;
      cycles(1);
      btn_set_n = 1'b0;
      cycles(9);
      btn_set_n = 1'b1;
      cycles(12);
      ec = {c0 + 11}; ev = {1};
      check_log("set bounce", ec, ev);

      btn_set_n = 1'b0; c0 = cyc; p = c0 + 7;
      cycles(37);
      btn_set_n = 1'b1; c1 = cyc;
      cycles(12);
      ec = {p}; ev = {1};
      for (int t = p + H; t <= c1 + 6; t += R) begin
         ec.push_back(t);
         ev.push_back(1);
      end
      check_log("set repeat", ec, ev);

      btn_mode_n = 1'b0; btn_set_n = 1'b0; c0 = cyc;
      cycles(20);
      btn_mode_n = 1'b1;
      cycles(20);
      chk("set still held", set_lvl, 1);
      ec = {c0 + 7}; ev = {2};
      check_log("both pressed", ec, ev);
      btn_set_n = 1'b1;
      cycles(12);
      btn_set_n = 1'b0; c2 = cyc;
      cycles(8);
      btn_set_n = 1'b1;
      cycles(12);
      ec = {c2 + 7}; ev = {1};
      check_log("set re-press", ec, ev);

      btn_set_n = 1'b0; c0 = cyc;
      cycles(19);
      ec = {c0 + 7, c0 + 17}; ev = {1, 1};
      check_log("pre-reset repeat", ec, ev);
      reset = 1'b0;
      cycles(1);
      chk("mid reset outputs", {button_state, mode_lvl, set_lvl}, 0);
      cycles(1);
      chk("mid reset outputs", {button_state, mode_lvl, set_lvl}, 0);
      reset = 1'b1; r = cyc;
      cycles(16);
      btn_set_n = 1'b1;
      cycles(12);
      ec = {r + 7, r + 17, r + 20}; ev = {1, 1, 1};
      check_log("held through reset", ec, ev);

      mh = 0; sh = 0; rh = 0;
      for (int i = 0; i < 3000; i++) begin
         if (mh == 0) begin
            btn_mode_n = ~btn_mode_n;
            mh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
         end
         if (sh == 0) begin
            btn_set_n = ~btn_set_n;
            sh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 60);
         end
         if (rh == 0 && $urandom_range(0, 499) == 0) rh = $urandom_range(1, 3);
         reset = (rh > 0) ? 1'b0 : 1'b1;
         if (rh > 0) rh--;
         mh--; sh--;
         cycles(1);
      end
      btn_mode_n = 1'b1; btn_set_n = 1'b1; reset = 1'b1;
      cycles(15);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
